f_d_queue: RTL and testbench
============================

F_D_QUEUE -- requirements
Module: f_d_queue

Interface
REQ-001 SHALL provide parameter DEPTH, default 8, meaning the number of f_d_pkg_t bundle entries; legal values are powers of two and >= 2.
REQ-002 SHALL provide port clk, input, 1 bit: the single clock; all state updates occur on its rising edge.
REQ-003 SHALL provide port rst, input, 1 bit: reset, synchronous and active-high.
REQ-004 SHALL provide port flush, input, 1 bit: backend redirect; discards all queued bundles.
REQ-005 SHALL provide port receiver, handshake_if.receiver carrying f_d_pkg_t (fields valid, ready, data): fetch-side input with mask[1:0], pc, insts[1:0], predict_infos.
REQ-006 SHALL provide port sender, handshake_if.sender carrying f_d_pkg_t: output to the decode stage.
REQ-007 SHALL provide port count_o, output, $clog2(DEPTH)+1 bits: the current number of stored bundles.

Function
REQ-008 SHALL define push as receiver.valid & receiver.ready, and pop as sender.valid & sender.ready.
REQ-009 SHALL drive receiver.ready = (count_o != DEPTH) & ~flush; it SHALL have no combinational dependence on sender.ready.
REQ-010 SHALL drive sender.valid = (count_o != 0) & ~flush, and sender.data = storage[rd_ptr], taken only from registered storage with no input-to-output bypass.
REQ-011 SHALL accept a pushed bundle whose mask is 2'b00 and discard it, leaving storage, wr_ptr and count unchanged.
REQ-012 SHALL store each pushed bundle with nonzero mask unmodified: all fields, including predict_infos, pc, mask and insts, bit-exact.
REQ-013 SHALL write a stored bundle at wr_ptr and advance wr_ptr by 1 modulo DEPTH.
REQ-014 SHALL advance rd_ptr by 1 modulo DEPTH on a pop.
REQ-015 SHALL update count as follows: +1 on a stored push without pop; -1 on a pop without stored push; unchanged when both occur in the same cycle, or when neither occurs.
REQ-016 SHALL present a bundle pushed into an empty queue on sender.valid in the next cycle, giving a latency of exactly 1 cycle.
REQ-017 SHALL emit bundles in strict push order with no loss or duplication.
REQ-018 SHALL hold sender.data stable while sender.valid=1 and sender.ready=0.
REQ-019 SHALL, when full, deassert receiver.ready; a pop at full SHALL raise receiver.ready in the following cycle, not the same cycle.
REQ-020 SHALL, when flush=1 and rst=0, set rd_ptr=0, wr_ptr=0 and count=0 at the next edge; no push or pop occurs in the flush cycle.
REQ-021 SHALL NOT give storage contents any reset or flush value; sender.data is don't-care while sender.valid=0.

Reset
REQ-022 SHALL, when rst=1 at a clock edge, set rd_ptr=0, wr_ptr=0 and count_o=0; rst takes priority over flush, push and pop.
REQ-023 SHALL, after reset, produce sender.valid=0, receiver.ready=1 and count_o=0 (receiver.ready follows REQ-009 and is 0 while flush is high).
REQ-024 SHALL, when reset is asserted mid-operation, discard all queued bundles and accept none in the reset cycle.

Verification (DEPTH=4)
REQ-025 SHALL verify fill-to-full: push 4 bundles with pc 0x1c000000, 0x1c000008, 0x1c000010, 0x1c000018, mask 2'b11, sender.ready=0 -> count_o=4 and receiver.ready=0; then sender.ready=1 for 4 cycles -> the pcs emerge in the same order, count_o=0 and sender.valid=0.
REQ-026 SHALL verify empty-mask drop: push mask 2'b00 (pc 0x1c000020), then mask 2'b10 (pc 0x1c000028) -> only pc 0x1c000028 is emitted, with mask 2'b10 and insts/predict_infos unchanged.
REQ-027 SHALL verify simultaneous push and pop at count=2 -> count stays 2; across 10 such cycles the pointers wrap and output order is preserved.
REQ-028 SHALL verify flush with 3 bundles queued while receiver.valid=1 -> in the flush cycle receiver.ready=0 and sender.valid=0; next cycle count_o=0 and the first new push appears after 1 cycle.
REQ-029 SHALL verify full then pop: in the pop cycle receiver.ready stays 0; the next cycle it is 1, and a push that cycle restores count_o=4.
REQ-030 SHALL verify rst=1 together with flush=1 and push at count=3 -> count_o=0, sender.valid=0 and the pushed bundle is never emitted.

Source files
------------

// File: rtl/f_d_queue_if.sv
// Fetch-to-decode bundle type and the valid/ready handshake interface that carries it.
package f_d_pkg;
  typedef struct packed {
    logic        taken;
    logic [31:0] target;
  } predict_info_t;

  typedef struct packed {
    logic [1:0]          mask;
    logic [31:0]         pc;
    logic [1:0][31:0]    insts;
    predict_info_t [1:0] predict_infos;
  } f_d_pkg_t;
endpackage

interface handshake_if;
  logic               valid;
  logic               ready;
  f_d_pkg::f_d_pkg_t  data;

  modport receiver (input valid, input data, output ready);
  modport sender   (output valid, output data, input ready);
endinterface

// File: rtl/f_d_queue.sv
// Fetch/decode decoupling queue: circular buffer of fetch bundles with flush and
// drop of empty-mask bundles; output is taken only from registered storage.
module f_d_queue #(
  parameter int unsigned DEPTH = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush,
  handshake_if.receiver          receiver,
  handshake_if.sender            sender,
  output logic [$clog2(DEPTH):0] count_o
);
  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  f_d_pkg::f_d_pkg_t mem_q [DEPTH];
  logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]     count_q, count_d;
  logic              push, store, pop;

  // Handshake flags depend only on registered count and flush.
  assign receiver.ready = (count_q != CW'(DEPTH)) & ~flush;
  assign sender.valid   = (count_q != '0) & ~flush;
  assign sender.data    = mem_q[rd_ptr_q];
  assign count_o        = count_q;

  always_comb begin
    push     = receiver.valid & receiver.ready;
    store    = push & (receiver.data.mask != 2'b00);
    pop      = sender.valid & sender.ready;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (store) wr_ptr_d = wr_ptr_q + PW'(1);
      if (pop)   rd_ptr_d = rd_ptr_q + PW'(1);
      count_d = count_q + CW'(store) - CW'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage carries no reset value; a write during reset is harmless since pointers clear.
  always_ff @(posedge clk) begin
    if (store) mem_q[wr_ptr_q] <= receiver.data;
  end
endmodule

// File: tb/tb_f_d_queue.sv
// Bench for f_d_queue (DEPTH=4): queue-based reference model checked every cycle,
// plus directed scenarios with hand-computed literal expectations.
module tb_f_d_queue;
  import f_d_pkg::*;

  localparam int DEPTH = 4;
  localparam int W     = $bits(f_d_pkg_t);

  logic clk = 1'b0;
  logic rst;
  logic flush;
  logic [$clog2(DEPTH):0] count_o;

  handshake_if in_if ();
  handshake_if out_if ();

  f_d_queue #(.DEPTH(DEPTH)) dut (
    .clk      (clk),
    .rst      (rst),
    .flush    (flush),
    .receiver (in_if),
    .sender   (out_if),
    .count_o  (count_o)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  f_d_pkg_t model_q [$];
  f_d_pkg_t emitted [$];
  bit       started = 1'b0;
  bit       do_pop, do_push;

  task automatic chk(input string nm, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", nm, got, exp, $time);
    end
  endtask

  function automatic f_d_pkg_t mk(input logic [31:0] pc, input logic [1:0] mask);
    f_d_pkg_t b;
    b.mask  = mask;
    b.pc    = pc;
    b.insts[0] = pc ^ 32'h0000_0013;
    b.insts[1] = pc ^ 32'h00a0_0093;
    b.predict_infos[0].taken  = pc[3];
    b.predict_infos[0].target = pc + 32'h40;
    b.predict_infos[1].taken  = ~pc[3];
    b.predict_infos[1].target = pc + 32'h80;
    return b;
  endfunction

  // Reference model: FIFO of stored bundles, updated from the bench's own inputs.
  always @(posedge clk) begin
    if (rst) begin
      model_q.delete();
    end else if (flush) begin
      model_q.delete();
    end else begin
      do_pop  = out_if.ready && (model_q.size() != 0);
      do_push = in_if.valid && (model_q.size() != DEPTH);
      if (do_pop) begin
        emitted.push_back(out_if.data);
        void'(model_q.pop_front());
      end
      if (do_push && in_if.data.mask != 2'b00) model_q.push_back(in_if.data);
    end
    started <= 1'b1;
  end

  // Per-cycle comparison against the model, sampled mid-cycle.
  always @(negedge clk) begin
    if (started) begin
      bit exp_valid;
      exp_valid = (model_q.size() != 0) && !flush;
      chk("count_o", W'(count_o), W'(model_q.size()));
      chk("rcv_ready", W'(in_if.ready), W'((model_q.size() != DEPTH) && !flush));
      chk("snd_valid", W'(out_if.valid), W'(exp_valid));
      if (exp_valid) chk("snd_data", out_if.data, model_q[0]);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  task automatic fill(input logic [31:0] base, input int n);
    for (int i = 0; i < n; i++) begin
      in_if.valid = 1'b1;
      in_if.data  = mk(base + 32'(8 * i), 2'b11);
      tick();
    end
    in_if.valid = 1'b0;
  endtask

  task automatic drain(input int n);
    out_if.ready = 1'b1;
    repeat (n) tick();
    out_if.ready = 1'b0;
  endtask

  int base;
  int found;

  initial begin
    rst = 1'b1; flush = 1'b0;
    in_if.valid = 1'b0; in_if.data = '0; out_if.ready = 1'b0;
    repeat (2) tick();
    rst = 1'b0;
    mid();
    chk("reset_count", W'(count_o), W'(0));
    chk("reset_valid", W'(out_if.valid), W'(0));
    chk("reset_ready", W'(in_if.ready), W'(1));
    tick();

    // Fill to full, then drain in order.
    fill(32'h1c00_0000, 4);
    mid();
    chk("full_count", W'(count_o), W'(4));
    chk("full_ready", W'(in_if.ready), W'(0));
    base = emitted.size();
    tick();
    drain(4);
    mid();
    chk("drained_count", W'(count_o), W'(0));
    chk("drained_valid", W'(out_if.valid), W'(0));
    chk("drain_n", W'(emitted.size() - base), W'(4));
    if (emitted.size() - base == 4) begin
      chk("drain_pc0", W'(emitted[base].pc),   W'(32'h1c00_0000));
      chk("drain_pc1", W'(emitted[base+1].pc), W'(32'h1c00_0008));
      chk("drain_pc2", W'(emitted[base+2].pc), W'(32'h1c00_0010));
      chk("drain_pc3", W'(emitted[base+3].pc), W'(32'h1c00_0018));
    end
    tick();

    // Empty-mask bundle is dropped; partial-mask bundle kept bit-exact.
    base = emitted.size();
    in_if.valid = 1'b1; in_if.data = mk(32'h1c00_0020, 2'b00); tick();
    in_if.data = mk(32'h1c00_0028, 2'b10); tick();
    in_if.valid = 1'b0;
    drain(3);
    mid();
    chk("drop_n", W'(emitted.size() - base), W'(1));
    if (emitted.size() > base) chk("drop_bundle", emitted[base], mk(32'h1c00_0028, 2'b10));
    tick();

    // Simultaneous push and pop at count 2 across pointer wrap.
    base = emitted.size();
    fill(32'h1c00_0100, 2);
    for (int i = 0; i < 10; i++) begin
      in_if.valid = 1'b1; out_if.ready = 1'b1;
      in_if.data = mk(32'h1c00_0200 + 32'(8 * i), 2'b01);
      mid();
      chk("pp_count", W'(count_o), W'(2));
      tick();
    end
    in_if.valid = 1'b0;
    drain(3);
    mid();
    chk("pp_n", W'(emitted.size() - base), W'(12));
    if (emitted.size() - base == 12) begin
      for (int i = 0; i < 12; i++)
        chk("pp_order", W'(emitted[base+i].pc),
            W'((i < 2) ? 32'h1c00_0100 + 32'(8 * i) : 32'h1c00_0200 + 32'(8 * (i - 2))));
    end
    tick();

    // Flush with three queued bundles while input is valid.
    fill(32'h1c00_0300, 3);
    flush = 1'b1; in_if.valid = 1'b1; in_if.data = mk(32'h1c00_03f8, 2'b11);
    mid();
    chk("flush_ready", W'(in_if.ready), W'(0));
    chk("flush_valid", W'(out_if.valid), W'(0));
    tick();
    flush = 1'b0; in_if.data = mk(32'h1c00_0400, 2'b01);
    mid();
    chk("post_flush_count", W'(count_o), W'(0));
    tick();
    in_if.valid = 1'b0;
    mid();
    chk("post_flush_valid", W'(out_if.valid), W'(1));
    chk("post_flush_pc", W'(out_if.data.pc), W'(32'h1c00_0400));
    tick();
    drain(2);

    // Full, then pop: ready rises only the cycle after the pop.
    fill(32'h1c00_0500, 4);
    in_if.valid = 1'b1; out_if.ready = 1'b1; in_if.data = mk(32'h1c00_05f0, 2'b11);
    mid();
    chk("pop_full_ready", W'(in_if.ready), W'(0));
    tick();
    out_if.ready = 1'b0; in_if.data = mk(32'h1c00_05f8, 2'b11);
    mid();
    chk("after_pop_ready", W'(in_if.ready), W'(1));
    chk("after_pop_count", W'(count_o), W'(3));
    tick();
    in_if.valid = 1'b0;
    mid();
    chk("refill_count", W'(count_o), W'(4));
    tick();
    drain(5);

    // Reset beats flush and push with three queued bundles.
    base = emitted.size();
    fill(32'h1c00_0600, 3);
    rst = 1'b1; flush = 1'b1; in_if.valid = 1'b1; in_if.data = mk(32'h1c00_06e8, 2'b11);
    tick();
    rst = 1'b0; flush = 1'b0; in_if.valid = 1'b0;
    mid();
    chk("rst_count", W'(count_o), W'(0));
    chk("rst_valid", W'(out_if.valid), W'(0));
    tick();
    drain(4);
    found = 0;
    for (int i = base; i < emitted.size(); i++)
      if (emitted[i].pc == 32'h1c00_06e8 || emitted[i].pc[11:8] == 4'h6) found++;
    chk("rst_discard", W'(found), W'(0));
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
